// File: rtl/spi_slave_nw.sv
// spi_slave_nw: oversampled SPI slave with configurable word width, CPOL/CPHA mode,
// multi-word frames and a valid/ready transmit holding register.
//   clk, rst_n         system clock, asynchronous active-low reset
//   SCK, SSEL, MOSI    raw SPI pins (asynchronous, synchronised internally)
//   MISO               slave-to-master data (1 when idle, or z with SPI_MISO_TRISTATE_EN)
//   tx_data/valid/ready  one-word transmit holding register handshake
//   rx_data, rx_valid  last complete received word and its one-clk strobe
//   tx_underrun        TX_IDLE was loaded because no word was available
//   frame_abort        SSEL rose with a partial word
//   busy               SSEL active (synchronised)
// Optional macro SPI_MISO_TRISTATE_EN: release MISO (1'bz) while deselected.
module spi_slave_nw #(
  parameter int DW = 8,
  parameter bit CPOL = 1'b0,
  parameter bit CPHA = 1'b0,
  parameter logic [DW-1:0] TX_IDLE = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          SCK,
  input  logic          SSEL,
  input  logic          MOSI,
  output logic          MISO,
  input  logic [DW-1:0] tx_data,
  input  logic          tx_valid,
  output logic          tx_ready,
  output logic [DW-1:0] rx_data,
  output logic          rx_valid,
  output logic          tx_underrun,
  output logic          frame_abort,
  output logic          busy
);
  localparam int CW = $clog2(DW);
  logic [2:0] sck_s, ssel_s;
  logic [1:0] mosi_s;
  logic [CW-1:0] bitcnt;
  logic [DW-1:0] rx_shift, tx_shift, hold;
  logic hold_full, lead, trail, active, start, stop, smp, shf, load, last;
  assign lead = CPOL ? (sck_s[2] & ~sck_s[1]) : (~sck_s[2] & sck_s[1]);
  assign trail = CPOL ? (~sck_s[2] & sck_s[1]) : (sck_s[2] & ~sck_s[1]);
  assign active = ~ssel_s[1];
  assign start = ssel_s[2] & ~ssel_s[1];
  assign stop = ~ssel_s[2] & ssel_s[1];
  // A select start swallows any SCK edge detected in the same clk.
  assign smp = active & ~start & (CPHA ? trail : lead);
  assign shf = active & ~start & (CPHA ? lead : trail);
  // CPHA=0 needs the MSB on MISO before the first edge, hence the extra load at start.
  assign load = (shf & (bitcnt == '0)) | (~CPHA & start);
  assign last = bitcnt == CW'(DW - 1);
  assign tx_ready = ~hold_full;
  assign busy = active;
`ifdef SPI_MISO_TRISTATE_EN
  assign MISO = active ? tx_shift[DW-1] : 1'bz;
`else
  assign MISO = active ? tx_shift[DW-1] : 1'b1;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sck_s <= {3{CPOL}};
      ssel_s <= '1;
      mosi_s <= '0;
      bitcnt <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
      hold <= '0;
      hold_full <= 1'b0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      sck_s <= {sck_s[1:0], SCK};
      ssel_s <= {ssel_s[1:0], SSEL};
      mosi_s <= {mosi_s[0], MOSI};
      rx_valid <= smp & last;
      tx_underrun <= load & ~hold_full & ~tx_valid;
      frame_abort <= stop & (bitcnt != '0);
      if (!active) bitcnt <= '0;
      else if (smp) bitcnt <= last ? '0 : bitcnt + 1'b1;
      if (smp) rx_shift <= {rx_shift[DW-2:0], mosi_s[1]};
      if (smp & last) rx_data <= {rx_shift[DW-2:0], mosi_s[1]};
      // An empty holding register lets a same-clk write go straight to the shifter.
      if (load) tx_shift <= hold_full ? hold : (tx_valid ? tx_data : TX_IDLE);
      else if (shf) tx_shift <= {tx_shift[DW-2:0], 1'b0};
      if (load & hold_full) hold_full <= 1'b0;
      else if (tx_valid & ~hold_full & ~load) begin
        hold <= tx_data;
        hold_full <= 1'b1;
      end
    end
endmodule

// File: tb/tb_spi_slave_nw.sv
// tb_spi_slave_nw: directed bench for spi_slave_nw in modes 0, 1 and 3.
module tb_spi_slave_nw;
  logic clk = 1'b0, rst_n = 1'b0;
  logic sck0 = 1'b0, ssel0 = 1'b1, mosi0 = 1'b0, miso0, tx_valid0 = 1'b0, tx_ready0;
  logic rx_valid0, tx_underrun0, frame_abort0, busy0;
  logic [7:0] tx_data0 = '0, rx_data0;
  logic sck1 = 1'b0, ssel1 = 1'b1, mosi1 = 1'b0, miso1, tx_ready1;
  logic rx_valid1, tx_underrun1, frame_abort1, busy1;
  logic [7:0] rx_data1;
  logic sck3 = 1'b1, ssel3 = 1'b1, mosi3 = 1'b0, miso3, tx_valid3 = 1'b0, tx_ready3;
  logic rx_valid3, tx_underrun3, frame_abort3, busy3;
  logic [15:0] tx_data3 = '0, rx_data3;
  int checks = 0, errors = 0;
  int rxv0 = 0, und0 = 0, abt0 = 0, rxv1 = 0, und1 = 0, rxv3 = 0, und3 = 0;
`ifdef SPI_MISO_TRISTATE_EN
  logic idle_miso = 1'bz;
`else
  logic idle_miso = 1'b1;
`endif

  always #5 clk = ~clk;

  spi_slave_nw #(.DW(8), .CPOL(1'b0), .CPHA(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .SCK(sck0), .SSEL(ssel0), .MOSI(mosi0), .MISO(miso0),
    .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0), .rx_data(rx_data0),
    .rx_valid(rx_valid0), .tx_underrun(tx_underrun0), .frame_abort(frame_abort0), .busy(busy0));

  spi_slave_nw #(.DW(8), .CPOL(1'b0), .CPHA(1'b1), .TX_IDLE(8'hFF)) u1 (
    .clk(clk), .rst_n(rst_n), .SCK(sck1), .SSEL(ssel1), .MOSI(mosi1), .MISO(miso1),
    .tx_data(8'h00), .tx_valid(1'b0), .tx_ready(tx_ready1), .rx_data(rx_data1),
    .rx_valid(rx_valid1), .tx_underrun(tx_underrun1), .frame_abort(frame_abort1), .busy(busy1));

  spi_slave_nw #(.DW(16), .CPOL(1'b1), .CPHA(1'b1)) u3 (
    .clk(clk), .rst_n(rst_n), .SCK(sck3), .SSEL(ssel3), .MOSI(mosi3), .MISO(miso3),
    .tx_data(tx_data3), .tx_valid(tx_valid3), .tx_ready(tx_ready3), .rx_data(rx_data3),
    .rx_valid(rx_valid3), .tx_underrun(tx_underrun3), .frame_abort(frame_abort3), .busy(busy3));

  always @(posedge clk) begin
    if (rx_valid0) rxv0 <= rxv0 + 1;
    if (tx_underrun0) und0 <= und0 + 1;
    if (frame_abort0) abt0 <= abt0 + 1;
    if (rx_valid1) rxv1 <= rxv1 + 1;
    if (tx_underrun1) und1 <= und1 + 1;
    if (rx_valid3) rxv3 <= rxv3 + 1;
    if (tx_underrun3) und3 <= und3 + 1;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Mode 0 master: drive MOSI, sample MISO, then raise and lower SCK.
  task automatic m0_bits(input logic [7:0] mo, input int n, output logic [7:0] mi);
    mi = '0;
    for (int i = 7; i > 7 - n; i--) begin
      mosi0 = mo[i];
      wait_clk(8);
      mi[i] = miso0;
      sck0 = 1'b1;
      wait_clk(8);
      sck0 = 1'b0;
    end
  endtask

  // Mode 1 master: rising edge shifts, falling edge samples.
  task automatic m1_word(input logic [7:0] mo, output logic [7:0] mi);
    mi = '0;
    for (int i = 7; i >= 0; i--) begin
      sck1 = 1'b1;
      mosi1 = mo[i];
      wait_clk(8);
      mi[i] = miso1;
      sck1 = 1'b0;
      wait_clk(8);
    end
  endtask

  // Mode 3 master: falling edge shifts, rising edge samples.
  task automatic m3_word(input logic [15:0] mo, output logic [15:0] mi);
    mi = '0;
    for (int i = 15; i >= 0; i--) begin
      sck3 = 1'b0;
      mosi3 = mo[i];
      wait_clk(8);
      mi[i] = miso3;
      sck3 = 1'b1;
      wait_clk(8);
    end
  endtask

  task automatic push3(input logic [15:0] w);
    int n = 0;
    while (!tx_ready3 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("m3_tx_ready_wait", 32'(tx_ready3), 32'd1);
    tx_data3 = w;
    tx_valid3 = 1'b1;
    @(negedge clk);
    tx_valid3 = 1'b0;
  endtask

  task automatic chk_reset0(input string tag);
    chk({tag, "_tx_ready"}, 32'(tx_ready0), 32'd1);
    chk({tag, "_rx_data"}, 32'(rx_data0), 32'd0);
    chk({tag, "_rx_valid"}, 32'(rx_valid0), 32'd0);
    chk({tag, "_underrun"}, 32'(tx_underrun0), 32'd0);
    chk({tag, "_abort"}, 32'(frame_abort0), 32'd0);
    chk({tag, "_busy"}, 32'(busy0), 32'd0);
    chk({tag, "_miso"}, 32'(miso0), 32'(idle_miso));
  endtask

  initial begin
    logic [7:0] a, b;
    logic [15:0] r0, r1, r2;
    int s_rxv, s_und, s_abt;
    wait_clk(1);
    #1;
    chk_reset0("reset");
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(4);
    // Mode 0: pre-queued 0xA5 out, 0x3C in.
    tx_data0 = 8'hA5;
    tx_valid0 = 1'b1;
    wait_clk(1);
    tx_valid0 = 1'b0;
    chk("m0_hold_full", 32'(tx_ready0), 32'd0);
    s_rxv = rxv0;
    s_und = und0;
    ssel0 = 1'b0;
    wait_clk(8);
    chk("m0_busy", 32'(busy0), 32'd1);
    m0_bits(8'h3C, 8, a);
    wait_clk(8);
    ssel0 = 1'b1;
    wait_clk(8);
    chk("m0_miso_word", 32'(a), 32'hA5);
    chk("m0_rx_data", 32'(rx_data0), 32'h3C);
    chk("m0_rx_valid_cnt", 32'(rxv0 - s_rxv), 32'd1);
    chk("m0_tx_ready", 32'(tx_ready0), 32'd1);
    chk("m0_underrun_cnt", 32'(und0 - s_und), 32'd1);
    chk("m0_idle_miso", 32'(miso0), 32'(idle_miso));
    // Mode 1 underrun: nothing queued, TX_IDLE=0xFF for both words.
    s_rxv = rxv1;
    s_und = und1;
    ssel1 = 1'b0;
    wait_clk(8);
    m1_word(8'h12, a);
    m1_word(8'h34, b);
    wait_clk(8);
    ssel1 = 1'b1;
    wait_clk(8);
    chk("m1_word0", 32'(a), 32'hFF);
    chk("m1_word1", 32'(b), 32'hFF);
    chk("m1_underrun_cnt", 32'(und1 - s_und), 32'd2);
    chk("m1_rx_valid_cnt", 32'(rxv1 - s_rxv), 32'd2);
    chk("m1_rx_data", 32'(rx_data1), 32'h34);
    // Mode 3, DW=16: three words queued one by one on tx_ready.
    s_rxv = rxv3;
    s_und = und3;
    push3(16'h1234);
    fork
      begin
        push3(16'hBEEF);
        push3(16'h0001);
      end
      begin
        ssel3 = 1'b0;
        wait_clk(8);
        m3_word(16'hCAFE, r0);
        m3_word(16'h0F0F, r1);
        m3_word(16'h8001, r2);
        wait_clk(8);
        ssel3 = 1'b1;
        wait_clk(8);
      end
    join
    chk("m3_word0", 32'(r0), 32'h1234);
    chk("m3_word1", 32'(r1), 32'hBEEF);
    chk("m3_word2", 32'(r2), 32'h0001);
    chk("m3_rx_valid_cnt", 32'(rxv3 - s_rxv), 32'd3);
    chk("m3_underrun_cnt", 32'(und3 - s_und), 32'd0);
    chk("m3_rx_data", 32'(rx_data3), 32'h8001);
    // Abort after 5 bits, then a clean 0x81 frame.
    s_rxv = rxv0;
    s_abt = abt0;
    ssel0 = 1'b0;
    wait_clk(8);
    m0_bits(8'hF8, 5, a);
    wait_clk(8);
    ssel0 = 1'b1;
    wait_clk(8);
    chk("abort_cnt", 32'(abt0 - s_abt), 32'd1);
    chk("abort_no_rx_valid", 32'(rxv0 - s_rxv), 32'd0);
    chk("abort_rx_data_kept", 32'(rx_data0), 32'h3C);
    ssel0 = 1'b0;
    wait_clk(8);
    m0_bits(8'h81, 8, a);
    wait_clk(8);
    ssel0 = 1'b1;
    wait_clk(8);
    chk("after_abort_rx_data", 32'(rx_data0), 32'h81);
    chk("after_abort_rx_valid_cnt", 32'(rxv0 - s_rxv), 32'd1);
    chk("after_abort_no_abort", 32'(abt0 - s_abt), 32'd1);
    // Reset in the middle of a word, with a word queued.
    tx_data0 = 8'h77;
    tx_valid0 = 1'b1;
    wait_clk(1);
    tx_valid0 = 1'b0;
    ssel0 = 1'b0;
    wait_clk(8);
    m0_bits(8'hF0, 4, a);
    rst_n = 1'b0;
    #1;
    chk_reset0("midreset");
    ssel0 = 1'b1;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(4);
    s_rxv = rxv0;
    tx_data0 = 8'h5A;
    tx_valid0 = 1'b1;
    wait_clk(1);
    tx_valid0 = 1'b0;
    ssel0 = 1'b0;
    wait_clk(8);
    m0_bits(8'hC3, 8, a);
    wait_clk(8);
    ssel0 = 1'b1;
    wait_clk(8);
    chk("post_reset_miso_word", 32'(a), 32'h5A);
    chk("post_reset_rx_data", 32'(rx_data0), 32'hC3);
    chk("post_reset_rx_valid_cnt", 32'(rxv0 - s_rxv), 32'd1);
    chk("idle_miso_u1", 32'(miso1), 32'(idle_miso));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
